// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the button gesture decoder: state encoding and event bit layout.
package key_event_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HELD  = 3'd1,
    ST_LONG  = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_HELD2 = 3'd4
  } key_state_e;

  // Event bit indices as consumed by the fan control FSM
  localparam int unsigned EVT_SHORT  = 0;
  localparam int unsigned EVT_LONG   = 1;
  localparam int unsigned EVT_REPEAT = 2;
  localparam int unsigned EVT_DOUBLE = 3;
  localparam int unsigned EVT_W      = 4;

  typedef struct packed {
    logic dbl_evt;
    logic rpt_evt;
    logic lng_evt;
    logic shrt_evt;
  } key_evt_t;

endpackage

// File: rtl/key_event_decoder.sv
// Classifies debounced button activity into short/long/repeat/double one-cycle event pulses.
// One instance per button; a single shared counter times every phase of the gesture.
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned REPEAT_TICKS = 200,
  parameter int unsigned DCLICK_TICKS = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic stable_flag,
  input  logic press,
  output logic short_evt,
  output logic long_evt,
  output logic repeat_evt,
  output logic double_evt,
  output logic busy
);

  localparam logic [63:0] TICK_MAX = (64'd1 << CNT_W) - 64'd1;

  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $error("key_event_decoder: CNT_W out of range");
  end
  if (LONG_TICKS < 2 || 64'(LONG_TICKS) > TICK_MAX) begin : g_bad_long
    $error("key_event_decoder: LONG_TICKS out of range");
  end
  if (REPEAT_TICKS < 2 || 64'(REPEAT_TICKS) > TICK_MAX) begin : g_bad_repeat
    $error("key_event_decoder: REPEAT_TICKS out of range");
  end
  if (DCLICK_TICKS < 2 || 64'(DCLICK_TICKS) > TICK_MAX) begin : g_bad_dclick
    $error("key_event_decoder: DCLICK_TICKS out of range");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_evt_t         evt_q, evt_d;
  logic             busy_q;

  // Next state, next count and next event pulses; release always beats a terminal count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    evt_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (press) state_d = ST_HELD;
      end
      ST_HELD: begin
        if (!stable_flag) begin
          state_d = ST_WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d       = ST_LONG;
          cnt_d         = '0;
          evt_d.lng_evt = 1'b1;
        end
      end
      ST_LONG: begin
        if (!stable_flag) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d         = '0;
          evt_d.rpt_evt = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (press) begin
          state_d = ST_HELD2;
          cnt_d   = '0;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d        = ST_IDLE;
          cnt_d          = '0;
          evt_d.shrt_evt = 1'b1;
        end
      end
      ST_HELD2: begin
        if (!stable_flag) begin
          state_d       = ST_IDLE;
          cnt_d         = '0;
          evt_d.dbl_evt = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          // First click completed as a short, second click became a long hold
          state_d        = ST_LONG;
          cnt_d          = '0;
          evt_d.shrt_evt = 1'b1;
          evt_d.lng_evt  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and all outputs are registered together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      evt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign short_evt  = evt_q.shrt_evt;
  assign long_evt   = evt_q.lng_evt;
  assign repeat_evt = evt_q.rpt_evt;
  assign double_evt = evt_q.dbl_evt;
  assign busy       = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed vector table, hand sequences, random gestures.
module tb_key_event_decoder;

  localparam int unsigned L = 20;
  localparam int unsigned R = 8;
  localparam int unsigned D = 10;

  // Expected output word layout: {busy, double, repeat, long, short}
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] BZ = 5'b10000;
  localparam logic [4:0] SH = 5'b00001;
  localparam logic [4:0] LG = 5'b00010;
  localparam logic [4:0] RP = 5'b00100;
  localparam logic [4:0] DB = 5'b01000;

  logic clk = 1'b0;
  logic reset;
  logic stable_flag;
  logic press;
  logic short_evt, long_evt, repeat_evt, double_evt, busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic       p;
    logic       s;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model: gesture ages in cycles
  bit m_active, m_held, m_second, m_long;
  int m_hold, m_gap;

  key_event_decoder #(
    .CNT_W       (16),
    .LONG_TICKS  (L),
    .REPEAT_TICKS(R),
    .DCLICK_TICKS(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stable_flag(stable_flag),
    .press      (press),
    .short_evt  (short_evt),
    .long_evt   (long_evt),
    .repeat_evt (repeat_evt),
    .double_evt (double_evt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {busy, double_evt, repeat_evt, long_evt, short_evt};
  endfunction

  task automatic check(input logic [4:0] exp, input string tag);
    logic [4:0] act;
    act = outs();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got {busy,dbl,rpt,lng,sh}=%b expected %b", tag, $time, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic s, input logic [4:0] exp, input string tag);
    @(negedge clk);
    press       = p;
    stable_flag = s;
    @(posedge clk);
    #1;
    check(exp, tag);
  endtask

  task automatic add(input int n, input logic p, input logic s, input logic [4:0] ev, input logic b);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.p   = p;
      v.s   = s;
      v.exp = {b, ev[3:0]};
      tbl.push_back(v);
    end
  endtask

  task automatic model_step(input logic p, input logic s, output logic [4:0] exp);
    logic [3:0] ev;
    ev = '0;
    if (!m_active) begin
      if (p) begin
        m_active = 1; m_held = 1; m_second = 0; m_long = 0; m_hold = 0;
      end
    end else if (m_held) begin
      if (!s) begin
        if (!m_long && m_second) ev[3] = 1'b1;
        if (m_long || m_second) m_active = 0;
        else begin
          m_held = 0;
          m_gap  = 0;
        end
      end else begin
        m_hold++;
        if (!m_long && m_hold == int'(L)) begin
          ev[1]  = 1'b1;
          ev[0]  = m_second;
          m_long = 1;
        end else if (m_long && m_hold > int'(L) && (m_hold - int'(L)) % int'(R) == 0) begin
          ev[2] = 1'b1;
        end
      end
    end else begin
      if (p) begin
        m_held = 1; m_second = 1; m_hold = 0;
      end else begin
        m_gap++;
        if (m_gap == int'(D)) begin
          ev[0]    = 1'b1;
          m_active = 0;
        end
      end
    end
    exp = {m_active, ev};
  endtask

  initial begin
    logic [4:0] exp;
    logic       s_cur;
    logic       p;
    int         run;

    reset = 1'b1; press = 1'b0; stable_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(NO, "reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Idle: stable level without a press pulse is ignored
    add(3, 0, 1, NO, 0);
    // Short click: 5 held cycles, short 10 cycles after release
    add(1, 1, 1, NO, 1); add(4, 0, 1, NO, 1); add(1, 0, 0, NO, 1);
    add(9, 0, 0, NO, 1); add(1, 0, 0, SH, 0); add(1, 0, 0, NO, 0);
    // Double click: second press 3 cycles after release
    add(1, 1, 1, NO, 1); add(3, 0, 1, NO, 1); add(1, 0, 0, NO, 1); add(2, 0, 0, NO, 1);
    add(1, 1, 1, NO, 1); add(3, 0, 1, NO, 1); add(1, 0, 0, DB, 0); add(2, 0, 0, NO, 0);
    // Window boundary: press on the last window edge still forms a double
    add(1, 1, 1, NO, 1); add(1, 0, 1, NO, 1); add(1, 0, 0, NO, 1); add(9, 0, 0, NO, 1);
    add(1, 1, 1, NO, 1); add(1, 0, 1, NO, 1); add(1, 0, 0, DB, 0); add(1, 0, 0, NO, 0);
    // One edge too late: short already out, new gesture starts
    add(1, 1, 1, NO, 1); add(1, 0, 1, NO, 1); add(1, 0, 0, NO, 1); add(9, 0, 0, NO, 1);
    add(1, 0, 0, SH, 0); add(1, 1, 1, NO, 1); add(2, 0, 1, NO, 1); add(1, 0, 0, NO, 1);
    add(9, 0, 0, NO, 1); add(1, 0, 0, SH, 0); add(1, 0, 0, NO, 0);
    // Long hold of 45 cycles: long at 20, repeats at 28/36/44, release silent
    add(1, 1, 1, NO, 1); add(19, 0, 1, NO, 1); add(1, 0, 1, LG, 1);
    add(7, 0, 1, NO, 1); add(1, 0, 1, RP, 1); add(7, 0, 1, NO, 1); add(1, 0, 1, RP, 1);
    add(7, 0, 1, NO, 1); add(1, 0, 1, RP, 1); add(1, 0, 0, NO, 0); add(1, 0, 0, NO, 0);
    // Debouncer re-pulses every 4 cycles during a 15-cycle hold
    for (int i = 0; i < 15; i++) add(1, (i % 4) == 0, 1, NO, 1);
    add(1, 0, 0, NO, 1); add(9, 0, 0, NO, 1); add(1, 0, 0, SH, 0); add(1, 0, 0, NO, 0);
    // Second click held to the long threshold: short and long together
    add(1, 1, 1, NO, 1); add(1, 0, 1, NO, 1); add(1, 0, 0, NO, 1); add(1, 1, 1, NO, 1);
    add(19, 0, 1, NO, 1); add(1, 0, 1, SH | LG, 1); add(1, 0, 0, NO, 0); add(1, 0, 0, NO, 0);

    foreach (tbl[i]) step(tbl[i].p, tbl[i].s, tbl[i].exp, $sformatf("table[%0d]", i));

    // Reset during LONG after one repeat
    step(1, 1, BZ, "rst_press");
    for (int k = 1; k <= 30; k++)
      step(0, 1, (k == int'(L)) ? (BZ | LG) : (k == int'(L + R)) ? (BZ | RP) : BZ,
           $sformatf("rst_hold[%0d]", k));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check(NO, "async_reset_mid_long");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) step(0, 1, NO, "post_reset_held");
    step(0, 0, NO, "post_reset_release");
    step(1, 1, BZ, "post_reset_press");
    step(0, 0, BZ, "post_reset_click");
    for (int k = 0; k < 9; k++) step(0, 0, BZ, "post_reset_wait");
    step(0, 0, SH, "post_reset_short");

    // Randomized gestures against the reference model
    m_active = 0; m_held = 0; m_second = 0; m_long = 0; m_hold = 0; m_gap = 0;
    s_cur = 1'b0;
    run   = 5;
    for (int c = 0; c < 4000; c++) begin
      p = 1'b0;
      if (run == 0) begin
        s_cur = !s_cur;
        run   = s_cur ? int'($urandom_range(1, 50)) : int'($urandom_range(1, 14));
        if (s_cur) p = 1'b1;
      end else begin
        run--;
        if (s_cur && $urandom_range(0, 9) == 0) p = 1'b1;
      end
      model_step(p, s_cur, exp);
      step(p, s_cur, exp, $sformatf("random[%0d]", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
